// File: rtl/hilo_acc_unit.sv
// hilo_acc_unit
//   HI/LO special-register pair with per-half direct writes, same-cycle
//   write bypass and a two-cycle multiply-accumulate engine
//   (MADD / MADDU / MSUB / MSUBU).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   we_hi, we_lo        direct write enables for each half
//   hi_i, lo_i          direct write data
//   acc_start           multiply-accumulate request, accepted only when idle
//   acc_op              00 MADD, 01 MADDU, 10 MSUB, 11 MSUBU
//   acc_a, acc_b        operands, sampled with an accepted start
//   busy                high while the accumulate is in flight (MUL or ACC)
//   done                one-cycle pulse after the accumulate result lands
//   hi_o, lo_o          registered HI / LO
//   hi_fwd, lo_fwd      value HI / LO will hold after the coming edge
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | direct writes only; acc_start latches op and operands
// MUL   | 2*DATA_W product of the latched operands is registered
// ACC   | {hi,lo} +/- product written back; direct writes are dropped

module hilo_acc_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_hi,
   input  logic              we_lo,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   input  logic              acc_start,
   input  logic [1:0]        acc_op,
   input  logic [DATA_W-1:0] acc_a,
   input  logic [DATA_W-1:0] acc_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic [DATA_W-1:0] hi_fwd,
   output logic [DATA_W-1:0] lo_fwd
);

   localparam int PW = 2 * DATA_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_ACC  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [1:0]        op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [PW-1:0]     a_ext;
   logic [PW-1:0]     b_ext;
   logic [PW-1:0]     mul_res;
   logic [PW-1:0]     acc_res;

   // Extending both operands to 2*DATA_W and keeping the low 2*DATA_W bits
   // of the product gives the correct signed or unsigned result.
   always_comb begin
      if (op_q[0]) begin
         a_ext = {{DATA_W{1'b0}}, a_q};
         b_ext = {{DATA_W{1'b0}}, b_q};
      end else begin
         a_ext = {{DATA_W{a_q[DATA_W-1]}}, a_q};
         b_ext = {{DATA_W{b_q[DATA_W-1]}}, b_q};
      end
      mul_res = a_ext * b_ext;
      if (op_q[1]) begin
         acc_res = {hi_q, lo_q} - prod_q;
      end else begin
         acc_res = {hi_q, lo_q} + prod_q;
      end
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (we_hi) hi_d = hi_i;
            if (we_lo) lo_d = lo_i;
            if (acc_start) begin
               op_d    = acc_op;
               a_d     = acc_a;
               b_d     = acc_b;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            if (we_hi) hi_d = hi_i;
            if (we_lo) lo_d = lo_i;
            prod_d  = mul_res;
            state_d = S_ACC;
         end
         S_ACC: begin
            // The accumulate owns both halves this cycle.
            hi_d    = acc_res[PW-1:DATA_W];
            lo_d    = acc_res[DATA_W-1:0];
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // The next-state values are exactly the bypassed view of each half.
   assign hi_fwd = hi_d;
   assign lo_fwd = lo_d;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_hilo_acc_unit.sv
module tb_hilo_acc_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we_hi = 1'b0;
   logic        we_lo = 1'b0;
   logic [31:0] hi_i = '0;
   logic [31:0] lo_i = '0;
   logic        acc_start = 1'b0;
   logic [1:0]  acc_op = '0;
   logic [31:0] acc_a = '0;
   logic [31:0] acc_b = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic [31:0] hi_fwd;
   logic [31:0] lo_fwd;

   int total = 0;
   int bad   = 0;
   logic [63:0] sb[$];

   hilo_acc_unit #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .we_hi(we_hi), .we_lo(we_lo), .hi_i(hi_i), .lo_i(lo_i),
      .acc_start(acc_start), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
      .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o),
      .hi_fwd(hi_fwd), .lo_fwd(lo_fwd)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] acc,
                                         input logic [31:0] a, input logic [31:0] b);
      longint sa, sb_v;
      logic [63:0] p;
      sa   = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
      sb_v = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
      p    = 64'(sa * sb_v);
      return op[1] ? acc - p : acc + p;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
      we_hi = 1'b1; we_lo = 1'b1; hi_i = h; lo_i = l;
      tick();
      we_hi = 1'b0; we_lo = 1'b0;
   endtask

   task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic push, input logic [63:0] exp);
      acc_op = op; acc_a = a; acc_b = b; acc_start = 1'b1;
      if (push) sb.push_back(exp);
      tick();
      acc_start = 1'b0;
   endtask

   task automatic pop_cmp(input string tag);
      logic [63:0] e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         chk(tag, {hi_o, lo_o}, e);
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 6) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, 64'(done), 64'd1);
      pop_cmp(tag);
   endtask

   task automatic run_acc(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
      int n = 0;
      start(op, a, b, 1'b1, exp);
      while (done !== 1'b1 && n < 6) begin
         chk({tag, "_busy"}, 64'(busy), 64'd1);
         tick();
         n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'd2);
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_busy_off"}, 64'(busy), 64'd0);
      pop_cmp(tag);
      tick();
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int cnt;
      logic [63:0] m;
      logic [31:0] ra, rb;

      tick();
      tick();
      rst = 1'b0;
      chk("rst_hi_o", 64'(hi_o), 64'd0);
      chk("rst_lo_o", 64'(lo_o), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_fwd", {hi_fwd, lo_fwd}, 64'd0);

      // Direct write on both halves: bypass now, registers after the edge.
      we_hi = 1'b1; we_lo = 1'b1; hi_i = 32'h12345678; lo_i = 32'h9ABCDEF0;
      #1;
      chk("wr_fwd", {hi_fwd, lo_fwd}, 64'h12345678_9ABCDEF0);
      chk("wr_pre_reg", {hi_o, lo_o}, 64'd0);
      tick();
      we_hi = 1'b0; we_lo = 1'b0;
      chk("wr_reg", {hi_o, lo_o}, 64'h12345678_9ABCDEF0);
      chk("wr_done", 64'(done), 64'd0);

      // HI-only write.
      do_reset();
      we_hi = 1'b1; hi_i = 32'hAAAA5555; lo_i = 32'hFFFFFFFF;
      #1;
      chk("hi_only_fwd", {hi_fwd, lo_fwd}, 64'hAAAA5555_00000000);
      tick();
      we_hi = 1'b0;
      chk("hi_only_reg", {hi_o, lo_o}, 64'hAAAA5555_00000000);

      // Basic accumulates.
      do_reset();
      run_acc("madd", 2'b00, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE);
      do_reset();
      run_acc("maddu", 2'b01, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE);
      do_reset();
      run_acc("msubu_wrap", 2'b11, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF);
      run_acc("msub", 2'b10, 32'hFFFFFFFF, 32'd1, 64'h0);

      // Direct LO write during MUL is seen by ACC.
      set_hilo(32'd0, 32'd5);
      start(2'b01, 32'd3, 32'd3, 1'b1, 64'h19);
      we_lo = 1'b1; lo_i = 32'h10;
      #1;
      chk("haz_mul_fwd", 64'(lo_fwd), 64'h10);
      tick();
      we_lo = 1'b0;
      chk("haz_acc_fwd", {hi_fwd, lo_fwd}, 64'h19);
      wait_done("haz_mul_wr");

      // Direct write during ACC is dropped; fwd shows the result instead.
      set_hilo(32'd0, 32'd5);
      start(2'b01, 32'd3, 32'd3, 1'b1, 64'hE);
      tick();
      we_hi = 1'b1; we_lo = 1'b1; hi_i = 32'hDEAD0000; lo_i = 32'h0000BEEF;
      #1;
      chk("haz_acc_wr_fwd", {hi_fwd, lo_fwd}, 64'hE);
      tick();
      we_hi = 1'b0; we_lo = 1'b0;
      wait_done("haz_acc_wr");

      // Start while busy is ignored.
      set_hilo(32'd0, 32'd5);
      start(2'b01, 32'd3, 32'd3, 1'b1, 64'hE);
      acc_start = 1'b1; acc_op = 2'b00; acc_a = 32'd100; acc_b = 32'd100;
      tick();
      tick();
      acc_start = 1'b0;
      wait_done("haz_busy_start");
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done === 1'b1) cnt++;
      end
      chk("haz_busy_pulses", 64'(cnt), 64'd0);
      chk("haz_busy_idle", 64'(busy), 64'd0);
      chk("haz_busy_keep", {hi_o, lo_o}, 64'hE);

      // Reset during ACC aborts the write.
      set_hilo(32'd1, 32'd0);
      start(2'b00, 32'd4, 32'd4, 1'b0, 64'h0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_hilo", {hi_o, lo_o}, 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done === 1'b1) cnt++;
      end
      chk("abort_pulses", 64'(cnt), 64'd0);
      run_acc("after_abort", 2'b00, 32'd4, 32'd4, 64'h10);

      // Back-to-back: new start accepted in the done cycle.
      ra = $urandom;
      rb = $urandom;
      m = model(2'b00, 64'h10, ra, rb);
      start(2'b00, ra, rb, 1'b1, m);
      tick();
      tick();
      chk("b2b_done1", 64'(done), 64'd1);
      pop_cmp("b2b_first");
      ra = $urandom;
      rb = $urandom;
      m = model(2'b11, m, ra, rb);
      start(2'b11, ra, rb, 1'b1, m);
      chk("b2b_accept", 64'(busy), 64'd1);
      wait_done("b2b_second");

      ra = $urandom;
      rb = $urandom;
      run_acc("rand_msub", 2'b10, ra, rb, model(2'b10, {hi_o, lo_o}, ra, rb));

      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
